// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses a combinational imem and
// buffers fetched words in a small FIFO that feeds decode over valid/ready.
// Branch/jump redirects from execute reload the PC and flush the queue.
// Optional feature macro: FETCH_MISALIGN_CHK_EN (misaligned-redirect fault).
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FQ_DEPTH   = 2,
  parameter int          IMEM_BYTES = 64
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fetch_done,
  output logic        fetch_fault
);

  localparam int                 PTR_W      = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
  localparam int                 CNT_W      = $clog2(FQ_DEPTH + 1);
  localparam logic [31:0]        NOP        = 32'h0000_0033;
  localparam logic [31:0]        IMEM_LIMIT = 32'(IMEM_BYTES);
  localparam logic [CNT_W-1:0]   DEPTH_CNT  = CNT_W'(FQ_DEPTH);
  localparam logic [PTR_W-1:0]   PTR_ONE    = PTR_W'(1);
  localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

  // Architectural state
  logic [31:0]      pc_reg,     pc_next;
  logic [CNT_W-1:0] count_reg,  count_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic             fault_reg,  fault_next;

  // Queue storage (small, read asynchronously so a pushed word is at the head
  // right after the edge that wrote it)
  logic [31:0] fq_pc_mem    [FQ_DEPTH];
  logic [31:0] fq_instr_mem [FQ_DEPTH];

  logic        push;
  logic        pop;
  logic [31:0] redirect_target;
  logic        redirect_misaligned;

`ifdef FETCH_MISALIGN_CHK_EN
  // Misaligned targets are loaded as-is but latch a sticky fault that halts fetch.
  assign redirect_target     = redirect_pc;
  assign redirect_misaligned = (redirect_pc[1:0] != 2'b00);
`else
  // Without the checker the target is silently word-aligned.
  assign redirect_target     = redirect_pc & ~32'h0000_0003;
  assign redirect_misaligned = 1'b0;
`endif

  assign imem_addr   = pc_reg;
  assign fetch_done  = (pc_reg >= IMEM_LIMIT);
  assign fetch_fault = fault_reg;
  assign out_valid   = (count_reg != '0);
  assign out_pc      = out_valid ? fq_pc_mem[rd_ptr_reg]    : 32'h0000_0000;
  assign out_instr   = out_valid ? fq_instr_mem[rd_ptr_reg] : NOP;

  // A redirect suppresses both queue operations; a full queue may still accept
  // a push when its head leaves in the same cycle.
  assign pop  = out_valid & out_ready & ~redirect_valid;
  assign push = ~redirect_valid & ~fetch_done & ~fault_reg &
                ((count_reg < DEPTH_CNT) | pop);

  // Next-state computation for PC, pointers, occupancy and fault flag
  always_comb begin
    pc_next     = pc_reg;
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    fault_next  = fault_reg;

    if (redirect_valid) begin
      pc_next     = redirect_target;
      count_next  = '0;
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      if (redirect_misaligned) begin
        fault_next = 1'b1;
      end
    end else begin
      if (push) begin
        pc_next     = pc_reg + 32'd4;
        wr_ptr_next = wr_ptr_reg + PTR_ONE;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + CNT_ONE;
        2'b01:   count_next = count_reg - CNT_ONE;
        default: count_next = count_reg;
      endcase
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_reg     <= RESET_PC;
      count_reg  <= '0;
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      fault_reg  <= 1'b0;
    end else begin
      pc_reg     <= pc_next;
      count_reg  <= count_next;
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      fault_reg  <= fault_next;
    end
  end

  // Queue write port; contents need no reset because count gates visibility
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fq_pc_mem[wr_ptr_reg]    <= pc_reg;
      fq_instr_mem[wr_ptr_reg] <= imem_instr;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: streaming, back-pressure, redirects,
// mid-stream reset, fetch_done boundary and misaligned redirect handling.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        fetch_done;
  logic        fetch_fault;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] NOP = 32'h0000_0033;

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .fetch_done     (fetch_done),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 64-byte instruction memory image
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    if (a >= 32'd64) return 32'h0000_0000;
    case (a[5:2])
      4'd0:    return 32'h0094_0333;
      4'd8:    return 32'h0050_8513;
      default: return 32'hC0DE_0000 | a;
    endcase
  endfunction

  assign imem_instr = imem_word(imem_addr);

  // Advance one clock; inputs and outputs are handled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two reset edges, then release with decode stalled.
  task automatic do_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b1;
    tick();
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid);
    end
    checks++;
    if (out_pc !== 32'h0) begin
      errors++; $display("FAIL reset_pc got=%h exp=00000000", out_pc);
    end
    checks++;
    if (out_instr !== NOP) begin
      errors++; $display("FAIL reset_instr got=%h exp=%h", out_instr, NOP);
    end
    checks++;
    if (imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_addr got=%h exp=00000000", imem_addr);
    end
    checks++;
    if (fetch_done !== 1'b0 || fetch_fault !== 1'b0) begin
      errors++; $display("FAIL reset_flags got=%0b%0b exp=00", fetch_done, fetch_fault);
    end
    rst = 1'b0;
  endtask

  // Full-rate stream from 0x00 to 0x3C with decode always ready.
  task automatic test_stream();
    logic [31:0] exp_pc;
    do_reset();
    out_ready = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      tick();
      exp_pc = 32'(4 * (k - 1));
      $display("xfer pc=%h instr=%h valid=%0b done=%0b", out_pc, out_instr, out_valid, fetch_done);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_pc) begin
        errors++; $display("FAIL stream_pc got=%0b/%h exp=1/%h", out_valid, out_pc, exp_pc);
      end
      checks++;
      if (out_instr !== imem_word(exp_pc)) begin
        errors++; $display("FAIL stream_instr got=%h exp=%h", out_instr, imem_word(exp_pc));
      end
      checks++;
      if (fetch_done !== (k == 16)) begin
        errors++; $display("FAIL stream_done k=%0d got=%0b exp=%0b", k, fetch_done, (k == 16));
      end
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_instr !== NOP) begin
      errors++; $display("FAIL stream_drain got=%0b/%h exp=0/%h", out_valid, out_instr, NOP);
    end
  endtask

  // Back-pressure: queue saturates at two entries, then drains in order.
  task automatic test_back_to_back();
    logic [31:0] exp_seq [4];
    exp_seq = '{32'h0, 32'h4, 32'h8, 32'hC};
    do_reset();
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (imem_addr !== 32'h8) begin
      errors++; $display("FAIL stall_addr got=%h exp=00000008", imem_addr);
    end
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      $display("xfer pc=%h instr=%h valid=%0b", out_pc, out_instr, out_valid);
      checks++;
      if (out_valid !== 1'b1 || out_pc !== exp_seq[k]) begin
        errors++; $display("FAIL drain_order k=%0d got=%0b/%h exp=1/%h", k, out_valid, out_pc, exp_seq[k]);
      end
      tick();
    end
  endtask

  // Redirect into a full queue with decode stalled.
  task automatic test_redirect();
    do_reset();
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h20;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h20) begin
      errors++; $display("FAIL redir_flush got=%0b/%h exp=0/00000020", out_valid, imem_addr);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_instr !== 32'h0050_8513) begin
      errors++; $display("FAIL redir_first got=%0b/%h/%h exp=1/00000020/00508513", out_valid, out_pc, out_instr);
    end
  endtask

  // Redirect while decode is ready: the head must be dropped, not delivered.
  task automatic test_redirect_pop();
    do_reset();
    tick();
    tick();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL redir_pop_flush got=%0b exp=0", out_valid);
    end
    tick();
    checks++;
    if (out_pc !== 32'h10 || out_valid !== 1'b1) begin
      errors++; $display("FAIL redir_pop_head got=%0b/%h exp=1/00000010", out_valid, out_pc);
    end
    tick();
    checks++;
    if (out_pc !== 32'h14) begin
      errors++; $display("FAIL redir_pop_next got=%h exp=00000014", out_pc);
    end
  endtask

  // Reset asserted mid-stream restarts fetch at zero.
  task automatic test_midstream_reset();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();
    checks++;
    if (imem_addr !== 32'h18) begin
      errors++; $display("FAIL mid_addr got=%h exp=00000018", imem_addr);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h0) begin
      errors++; $display("FAIL mid_rst got=%0b/%h exp=0/00000000", out_valid, imem_addr);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0) begin
      errors++; $display("FAIL mid_refetch got=%0b/%h exp=1/00000000", out_valid, out_pc);
    end
  endtask

  // fetch_done boundary: redirect past the end, then back to the last word.
  task automatic test_fetch_done();
    do_reset();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h40;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (fetch_done !== 1'b1) begin
      errors++; $display("FAIL done_set got=%0b exp=1", fetch_done);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || imem_addr !== 32'h40) begin
      errors++; $display("FAIL done_nopush got=%0b/%h exp=0/00000040", out_valid, imem_addr);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h3C;
    tick();
    redirect_valid = 1'b0;
    checks++;
    if (fetch_done !== 1'b0) begin
      errors++; $display("FAIL done_clear got=%0b exp=0", fetch_done);
    end
    tick();
    checks++;
    if (out_pc !== 32'h3C || fetch_done !== 1'b1) begin
      errors++; $display("FAIL done_last got=%h/%0b exp=0000003c/1", out_pc, fetch_done);
    end
  endtask

  // Misaligned redirect target 0x22.
  task automatic test_misalign();
    do_reset();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h22;
    tick();
    redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    checks++;
    if (fetch_fault !== 1'b1 || imem_addr !== 32'h22) begin
      errors++; $display("FAIL mis_fault got=%0b/%h exp=1/00000022", fetch_fault, imem_addr);
    end
    for (int k = 0; k < 3; k++) tick();
    checks++;
    if (out_valid !== 1'b0 || fetch_fault !== 1'b1) begin
      errors++; $display("FAIL mis_halt got=%0b/%0b exp=0/1", out_valid, fetch_fault);
    end
`else
    checks++;
    if (fetch_fault !== 1'b0 || imem_addr !== 32'h20) begin
      errors++; $display("FAIL mis_align got=%0b/%h exp=0/00000020", fetch_fault, imem_addr);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h20 || out_instr !== 32'h0050_8513) begin
      errors++; $display("FAIL mis_resume got=%0b/%h/%h exp=1/00000020/00508513", out_valid, out_pc, out_instr);
    end
`endif
  endtask

  initial begin
    rst            = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    test_reset();
    test_stream();
    test_back_to_back();
    test_redirect();
    test_redirect_pop();
    test_midstream_reset();
    test_fetch_done();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
